order_issue_arbiter: RTL
========================

ORDER_ISSUE_ARBITER -- requirements
Module: order_issue_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 3: idle cycles forced after each issue so the processor (slowclk domain) can sample; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 HRESETn  input  1  asynchronous, active-low reset.
REQ-004 cpu_req_valid  input  1  CPU request present.
REQ-005 cpu_req_ready  output  1  CPU holding slot empty; handshake when valid and ready are both high at a rising edge.
REQ-006 cpu_req_new_max / cpu_req_client_id / cpu_req_amount  input  1/5/16  CPU request payload.
REQ-007 ex_req_valid / ex_req_ready  input/output  1/1  exchange request handshake, same rules as CPU.
REQ-008 ex_req_client_id / ex_req_amount  input  5/16  exchange request payload.
REQ-009 cpu_go, cpu_new_max, cpu_client_id, cpu_amount  output  1/1/5/16  CPU-side issue to the processor.
REQ-010 exchange_go, exchange_client_id, exchange_amount  output  1/5/16  exchange-side issue to the processor.
REQ-011 busy  output  1  high whenever state is not IDLE or either slot is full.
REQ-012 grant_cnt_cpu / grant_cnt_ex  output  16/16  issue counters (see Configuration).

Function
REQ-013 Each side has a one-entry holding slot; a handshake loads the payload and marks the slot full at that edge.
REQ-014 ready for a side is the registered slot-empty flag; a slot freed at an edge shows ready high in the following cycle, with no same-edge refill.
REQ-015 FSM states: IDLE, ISSUE, GAP.
REQ-016 IDLE: if any slot is full, select a winner and go to ISSUE at the next edge; otherwise stay.
REQ-017 Selection: a full CPU slot with new_max=1 wins unconditionally; otherwise, with both slots full, the side not granted last wins (round-robin); with one full, that side wins.
REQ-018 The round-robin pointer resets to "exchange granted last", so the first tie goes to CPU.
REQ-019 ISSUE lasts exactly one cycle: the winner's go is high, the payload is on its outputs, and the other side's go stays low; the winner's slot is freed at the end of ISSUE.
REQ-020 After ISSUE: if GAP_CYCLES=0, go to IDLE; otherwise go to GAP for exactly GAP_CYCLES cycles, then IDLE.
REQ-021 Minimum latency is 2 cycles, from the accepting edge to the edge at which go rises; the minimum spacing between go pulses is GAP_CYCLES+2 cycles.
REQ-022 Outside ISSUE, cpu_go and exchange_go are low; id, amount and new_max outputs hold the last issued value.
REQ-023 Requests may be accepted in any state, including ISSUE and GAP, whenever the slot is empty.
REQ-024 cpu_go and exchange_go are never high in the same cycle.

Reset
REQ-025 While HRESETn is low, all outputs, registers and both slots are 0 except the ready outputs. Ready outputs are 0 while reset is asserted and read 1 from the first edge after deassertion. The state is IDLE.
REQ-026 Reset asserted mid-ISSUE or mid-GAP drops go immediately (asynchronously) and discards held requests.

Configuration
REQ-027 Macro ORDER_ARB_STATS_EN is defined: grant_cnt_cpu and grant_cnt_ex increment on each ISSUE of their side, saturate at 16'hFFFF, and reset to 0.
REQ-028 Macro ORDER_ARB_STATS_EN is undefined: both counter ports exist, are tied to 0, and no counter logic is built.

Verification
REQ-029 Single CPU request (id 5'd3, amount 16'd100), GAP_CYCLES=3: cpu_go is high for one cycle, 2 cycles after acceptance; cpu_client_id=3, cpu_amount=100; busy drops 4 cycles after go.
REQ-030 Both slots loaded on the same edge, new_max=0, after reset: CPU issues first, then the exchange issues exactly 5 cycles later.
REQ-031 Exchange slot full and a CPU request with new_max=1 loaded on the same edge: CPU issues first, with cpu_new_max=1, and the exchange issues next.
REQ-032 Continuous valid on both sides for 20 issues: grants alternate CPU/exchange, go never overlaps, and with ORDER_ARB_STATS_EN each counter reads 10.
REQ-033 HRESETn pulsed low during GAP while the exchange slot is full: go is low immediately, and after release there is no issue and exchange_amount reads 0.
REQ-034 GAP_CYCLES=0 with both sides continuously valid: go pulses occur every 2 cycles, and ready toggles per REQ-014.

Source files
------------

// File: rtl/order_issue_arbiter.sv
// Two one-entry holding slots (CPU, exchange) feeding a paced one-cycle issue FSM.
// Optional saturating grant counters are built only when ORDER_ARB_STATS_EN is defined.
module order_issue_arbiter #(
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic        clk,
  input  logic        HRESETn,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_new_max,
  input  logic [4:0]  cpu_req_client_id,
  input  logic [15:0] cpu_req_amount,
  input  logic        ex_req_valid,
  output logic        ex_req_ready,
  input  logic [4:0]  ex_req_client_id,
  input  logic [15:0] ex_req_amount,
  output logic        cpu_go,
  output logic        cpu_new_max,
  output logic [4:0]  cpu_client_id,
  output logic [15:0] cpu_amount,
  output logic        exchange_go,
  output logic [4:0]  exchange_client_id,
  output logic [15:0] exchange_amount,
  output logic        busy,
  output logic [15:0] grant_cnt_cpu,
  output logic [15:0] grant_cnt_ex
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  localparam logic [3:0] GAP_INIT = (GAP_CYCLES == 32'd0) ? 4'd0 : 4'(GAP_CYCLES - 32'd1);

  state_t      state_r;
  logic        win_ex_r;
  logic        last_ex_r;
  logic [3:0]  gap_cnt_r;

  logic        cpu_full_r, cpu_ready_r, cpu_nm_r;
  logic [4:0]  cpu_id_r;
  logic [15:0] cpu_amt_r;
  logic        ex_full_r, ex_ready_r;
  logic [4:0]  ex_id_r;
  logic [15:0] ex_amt_r;

  logic        cpu_go_r, cpu_new_max_r, ex_go_r, busy_r;
  logic [4:0]  cpu_client_id_r, ex_client_id_r;
  logic [15:0] cpu_amount_r, ex_amount_r;

  logic        cpu_hs_s, ex_hs_s, free_cpu_s, free_ex_s;
  logic        cpu_full_nxt_s, ex_full_nxt_s, sel_ex_s;

  assign cpu_hs_s       = cpu_req_valid & cpu_ready_r;
  assign ex_hs_s        = ex_req_valid & ex_ready_r;
  assign free_cpu_s     = (state_r == ISSUE) & ~win_ex_r;
  assign free_ex_s      = (state_r == ISSUE) & win_ex_r;
  assign cpu_full_nxt_s = cpu_hs_s | (cpu_full_r & ~free_cpu_s);
  assign ex_full_nxt_s  = ex_hs_s | (ex_full_r & ~free_ex_s);

  // Winner selection: CPU new-max overrides, else round-robin on a tie, else the lone full side.
  always_comb begin
    sel_ex_s = 1'b0;
    if (cpu_full_r && cpu_nm_r) begin
      sel_ex_s = 1'b0;
    end else if (cpu_full_r && ex_full_r) begin
      sel_ex_s = ~last_ex_r;
    end else if (ex_full_r) begin
      sel_ex_s = 1'b1;
    end else begin
      sel_ex_s = 1'b0;
    end
  end

  // Holding slots; ready is the registered empty flag, so a freed slot refills one cycle later.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      cpu_full_r  <= 1'b0;
      cpu_ready_r <= 1'b0;
      cpu_nm_r    <= 1'b0;
      cpu_id_r    <= 5'd0;
      cpu_amt_r   <= 16'd0;
      ex_full_r   <= 1'b0;
      ex_ready_r  <= 1'b0;
      ex_id_r     <= 5'd0;
      ex_amt_r    <= 16'd0;
    end else begin
      cpu_full_r  <= cpu_full_nxt_s;
      cpu_ready_r <= ~cpu_full_nxt_s;
      ex_full_r   <= ex_full_nxt_s;
      ex_ready_r  <= ~ex_full_nxt_s;
      if (cpu_hs_s) begin
        cpu_nm_r  <= cpu_req_new_max;
        cpu_id_r  <= cpu_req_client_id;
        cpu_amt_r <= cpu_req_amount;
      end
      if (ex_hs_s) begin
        ex_id_r  <= ex_req_client_id;
        ex_amt_r <= ex_req_amount;
      end
    end
  end

  // Issue FSM; the processor-facing outputs are registered one cycle behind the state.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r         <= IDLE;
      win_ex_r        <= 1'b0;
      last_ex_r       <= 1'b1;
      gap_cnt_r       <= 4'd0;
      cpu_go_r        <= 1'b0;
      cpu_new_max_r   <= 1'b0;
      cpu_client_id_r <= 5'd0;
      cpu_amount_r    <= 16'd0;
      ex_go_r         <= 1'b0;
      ex_client_id_r  <= 5'd0;
      ex_amount_r     <= 16'd0;
      busy_r          <= 1'b0;
    end else begin
      cpu_go_r <= free_cpu_s;
      ex_go_r  <= free_ex_s;
      busy_r   <= (state_r != IDLE) | cpu_full_r | ex_full_r;
      case (state_r)
        IDLE: begin
          if (cpu_full_r || ex_full_r) begin
            win_ex_r  <= sel_ex_s;
            last_ex_r <= sel_ex_s;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          if (win_ex_r) begin
            ex_client_id_r <= ex_id_r;
            ex_amount_r    <= ex_amt_r;
          end else begin
            cpu_new_max_r   <= cpu_nm_r;
            cpu_client_id_r <= cpu_id_r;
            cpu_amount_r    <= cpu_amt_r;
          end
          if (GAP_CYCLES == 32'd0) begin
            state_r <= IDLE;
          end else begin
            state_r   <= GAP;
            gap_cnt_r <= GAP_INIT;
          end
        end
        GAP: begin
          if (gap_cnt_r == 4'd0) begin
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready      = cpu_ready_r;
  assign ex_req_ready       = ex_ready_r;
  assign cpu_go             = cpu_go_r;
  assign cpu_new_max        = cpu_new_max_r;
  assign cpu_client_id      = cpu_client_id_r;
  assign cpu_amount         = cpu_amount_r;
  assign exchange_go        = ex_go_r;
  assign exchange_client_id = ex_client_id_r;
  assign exchange_amount    = ex_amount_r;
  assign busy               = busy_r;

`ifdef ORDER_ARB_STATS_EN
  logic [15:0] cnt_cpu_r, cnt_ex_r;

  // Saturating per-side grant counters, advanced on every ISSUE cycle.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_cpu_r <= 16'd0;
      cnt_ex_r  <= 16'd0;
    end else begin
      if (free_cpu_s && (cnt_cpu_r != 16'hFFFF)) begin
        cnt_cpu_r <= cnt_cpu_r + 16'd1;
      end
      if (free_ex_s && (cnt_ex_r != 16'hFFFF)) begin
        cnt_ex_r <= cnt_ex_r + 16'd1;
      end
    end
  end

  assign grant_cnt_cpu = cnt_cpu_r;
  assign grant_cnt_ex  = cnt_ex_r;
`else
  assign grant_cnt_cpu = 16'd0;
  assign grant_cnt_ex  = 16'd0;
`endif

endmodule
